// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage buffer.
package pipe_pkg;
  typedef logic [1:0] occ_t;

  localparam int STALL_W    = 16;
  localparam int DATA_W_DEF = 128;
  localparam int CTRL_W_DEF = 24;

  // Bubble control value: an all-zero bundle decodes as a no-op downstream.
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;
endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Upstream/downstream valid-ready bus of the stage buffer.
interface pipe_stage_buffer_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_slot.sv
// One buffer slot: valid bit plus payload register with load and clear.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);
  logic         vld_q, vld_d;
  logic [W-1:0] q_q, q_d;

  // Clear drops only the valid bit; the payload keeps its last value.
  always_comb begin
    vld_d = vld_q;
    q_d   = q_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d = 1'b1;
      q_d   = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld_q <= 1'b0;
      q_q   <= '0;
    end else begin
      vld_q <= vld_d;
      q_q   <= q_d;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = q_q;
endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer with flush and stall counter.
// Build option PIPE_SKID_EN adds a skid slot with registered in_ready.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               flush,
  input  logic               stall_cnt_clr,
  pipe_stage_buffer_if.slave bus,
  output occ_t               occupancy,
  output logic [STALL_W-1:0] stall_cnt
);
  localparam int PW = DATA_W + CTRL_W;

  logic [PW-1:0]      in_beat, main_d, main_q;
  logic               main_vld, main_load, main_clr;
  logic               accept, deliver;
  logic [STALL_W-1:0] stall_q, stall_d;

  assign in_beat = {bus.in_ctrl, bus.in_data};
  assign accept  = bus.in_valid & bus.in_ready;
  assign deliver = main_vld & bus.out_ready;

`ifdef PIPE_SKID_EN
  logic [PW-1:0] skid_q;
  logic          skid_vld, skid_load, skid_clr;

  // Ready comes straight from the skid valid flop, never from out_ready.
  assign bus.in_ready = rst_b & ~flush & ~skid_vld;
  assign main_load    = (accept & (~main_vld | bus.out_ready)) | (deliver & skid_vld);
  assign main_clr     = flush | (deliver & ~skid_vld & ~accept);
  assign main_d       = skid_vld ? skid_q : in_beat;
  assign skid_load    = accept & main_vld & ~bus.out_ready;
  assign skid_clr     = flush | (deliver & skid_vld);
  assign occupancy    = occ_t'({1'b0, main_vld} + {1'b0, skid_vld});

  pipe_slot #(.W(PW)) u_skid (
    .clk    (clk),
    .rst_b  (rst_b),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .d_i    (in_beat),
    .vld_o  (skid_vld),
    .q_o    (skid_q)
  );
`else
  assign bus.in_ready = rst_b & ~flush & (~main_vld | bus.out_ready);
  assign main_load    = accept;
  assign main_clr     = flush | (deliver & ~accept);
  assign main_d       = in_beat;
  assign occupancy    = {1'b0, main_vld};
`endif

  pipe_slot #(.W(PW)) u_main (
    .clk    (clk),
    .rst_b  (rst_b),
    .load_i (main_load),
    .clr_i  (main_clr),
    .d_i    (main_d),
    .vld_o  (main_vld),
    .q_o    (main_q)
  );

  assign bus.out_valid = main_vld;
  assign bus.out_data  = main_q[DATA_W-1:0];
  assign bus.out_ctrl  = main_vld ? main_q[PW-1:DATA_W] : CTRL_BUBBLE;

  always_comb begin
    stall_d = stall_q;
    if (stall_cnt_clr) begin
      stall_d = '0;
    end else if (main_vld && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: vector table, scoreboard, corner sequences.
module tb_pipe_stage_buffer;
  localparam int DW = 128;
  localparam int CW = 24;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int          MAXOCC = SKID ? 2 : 1;
  localparam logic [CW-1:0] BUBBLE = '0;

  typedef struct {
    bit          iv, ordy, fl, clr;
    bit          e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [15:0] e_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_b, flush, stall_cnt_clr;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW+CW-1:0] sb_q[$];

  pipe_stage_buffer_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .flush         (flush),
    .stall_cnt_clr (stall_cnt_clr),
    .bus           (bus),
    .occupancy     (occupancy),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [151:0] act, input logic [151:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit iv, bit ordy, bit fl, bit clr, bit eov, bit eir,
                              logic [1:0] occ, logic [15:0] st);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.e_ov = eov; v.e_ir = eir; v.e_occ = occ; v.e_stall = st;
    return v;
  endfunction

  // From empty with out_ready low: load MAXOCC beats, stall_cnt cleared on the way in.
  task automatic fill();
    bus.out_ready = 1'b0;
    stall_cnt_clr = 1'b1;
    for (int k = 0; k < MAXOCC; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{$urandom}};
      bus.in_ctrl  = CW'($urandom);
      cyc();
      stall_cnt_clr = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: pop on delivery, push on acceptance; flush and reset discard everything.
  always @(negedge clk) begin
    if (!rst_b) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) chk("sb_unexpected_beat", 152'(1'b1), 152'(1'b0));
        else chk("sb_beat", 152'({bus.out_ctrl, bus.out_data}), 152'(sb_q.pop_front()));
      end
      if (flush) sb_q.delete();
      else if (bus.in_valid && bus.in_ready) sb_q.push_back({bus.in_ctrl, bus.in_data});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[13];
    int sent, got, bubbles;
    bit first;

    tv[0]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,   2'd0,16'd0);
    tv[1]  = mk(1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,   2'd1,16'd0);
    tv[2]  = mk(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,   2'd0,16'd0);
    tv[3]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,   2'd0,16'd0);
    tv[4]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b1,SKID,   2'd1,16'd0);
    tv[5]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b1,SKID,   2'd1,16'd1);
    tv[6]  = mk(1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,   2'd1,16'd2);
    tv[7]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,   2'd0,16'd2);
    tv[8]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,   2'd1,16'd2);
    tv[9]  = mk(1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,   2'd1,16'd2);
    tv[10] = mk(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,   2'd0,16'd2);
    tv[11] = mk(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,   2'd0,16'd2);
    tv[12] = mk(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,   2'd0,16'd0);

    rst_b = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) cyc();
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  152'(bus.in_ready),  152'(1'b0));
    chk("rst_out_valid", 152'(bus.out_valid), 152'(1'b0));
    chk("rst_out_ctrl",  152'(bus.out_ctrl),  152'(BUBBLE));
    chk("rst_out_data",  152'(bus.out_data),  152'(0));
    chk("rst_occ",       152'(occupancy),     152'(0));
    chk("rst_stall",     152'(stall_cnt),     152'(0));
    cyc();
    rst_b = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.in_valid  = tv[i].iv;
      bus.out_ready = tv[i].ordy;
      flush         = tv[i].fl;
      stall_cnt_clr = tv[i].clr;
      bus.in_data   = {$urandom, $urandom, $urandom, 32'(i)};
      bus.in_ctrl   = (i == 0) ? 24'h00ABCD : CW'(i * 32'h010101);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 152'(bus.out_valid), 152'(tv[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i),  152'(bus.in_ready),  152'(tv[i].e_ir));
      chk($sformatf("vec%0d_occ", i),       152'(occupancy),     152'(tv[i].e_occ));
      chk($sformatf("vec%0d_stall", i),     152'(stall_cnt),     152'(tv[i].e_stall));
      if (!tv[i].e_ov) chk($sformatf("vec%0d_bubble", i), 152'(bus.out_ctrl), 152'(BUBBLE));
      cyc();
    end
    flush = 1'b0; stall_cnt_clr = 1'b0; bus.in_valid = 1'b0;

    // Fill to capacity with downstream stalled, then drain in order
    fill();
    bus.in_valid = 1'b1;
    bus.in_data  = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    chk("full_occ",      152'(occupancy),    152'(MAXOCC));
    chk("full_in_ready", 152'(bus.in_ready), 152'(1'b0));
    chk("full_stall0",   152'(stall_cnt),    152'(SKID ? 1 : 0));
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_stall1", 152'(stall_cnt), 152'(SKID ? 2 : 1));
    cyc();
    bus.out_ready = 1'b1;
    for (int k = 0; k < MAXOCC; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_out_valid", k), 152'(bus.out_valid), 152'(1'b1));
      cyc();
    end
    @(negedge clk);
    chk("drain_done_valid", 152'(bus.out_valid), 152'(1'b0));
    chk("drain_done_occ",   152'(occupancy),     152'(0));
    cyc();

    // Flush at capacity with a beat offered
    fill();
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 152'(bus.in_ready), 152'(1'b0));
    cyc();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 152'(bus.out_valid), 152'(1'b0));
    chk("flush_out_ctrl",  152'(bus.out_ctrl),  152'(BUBBLE));
    chk("flush_occ",       152'(occupancy),     152'(0));
    cyc();
    @(negedge clk);
    chk("flush_no_accept", 152'(bus.out_valid), 152'(1'b0));
    cyc();

    // Stall counter saturation and clear
    fill();
    repeat (70000) cyc();
    @(negedge clk);
    chk("stall_sat", 152'(stall_cnt), 152'(16'hFFFF));
    cyc();
    stall_cnt_clr = 1'b1;
    cyc();
    stall_cnt_clr = 1'b0;
    @(negedge clk);
    chk("stall_clr", 152'(stall_cnt), 152'(0));
    cyc();

    // Reset mid-stream at capacity
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    fill();
    bus.in_valid = 1'b1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready0", 152'(bus.in_ready), 152'(1'b0));
    cyc();
    @(negedge clk);
    chk("mrst_in_ready1",  152'(bus.in_ready),  152'(1'b0));
    chk("mrst_out_valid",  152'(bus.out_valid), 152'(1'b0));
    chk("mrst_out_ctrl",   152'(bus.out_ctrl),  152'(BUBBLE));
    chk("mrst_out_data",   152'(bus.out_data),  152'(0));
    chk("mrst_occ",        152'(occupancy),     152'(0));
    chk("mrst_stall",      152'(stall_cnt),     152'(0));
    cyc();
    rst_b = 1'b1;
    bus.in_valid = 1'b0;

    // Back-to-back streaming of 100 incrementing beats
    sent = 0; got = 0; bubbles = 0; first = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      bus.in_valid = (sent < 100);
      bus.in_data  = DW'(sent);
      bus.in_ctrl  = CW'(sent + 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        got++;
        first = 1'b1;
      end else if (first) begin
        bubbles++;
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("stream_delivered", 152'(got),     152'(100));
    chk("stream_bubbles",   152'(bubbles), 152'(0));
    @(negedge clk);
    chk("sb_empty", 152'(sb_q.size()), 152'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of the datapath payload (operands, immediates, addresses).
REQ-002 SHALL have parameter CTRL_W, default 24, width of the control-signal bundle.
REQ-003 SHALL have parameter CTRL_BUBBLE, default all-zero, control value presented when no valid beat is held.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_b, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 SHALL have port in_ready, output, 1, stage accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-010 SHALL have port flush, input, 1, kill all held beats (branch/jump redirect).
REQ-011 SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-013 SHALL have port out_data, output, DATA_W, held payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W, held control, or CTRL_BUBBLE when out_valid=0.
REQ-015 SHALL have port occupancy, output, 2, number of beats held (0..2).
REQ-016 SHALL have port stall_cnt, output, 16, saturating count of cycles with out_valid=1 and out_ready=0.
REQ-017 SHALL have port stall_cnt_clr, input, 1, synchronous clear of stall_cnt.

Function
REQ-018 SHALL accept a beat iff in_valid=1 and in_ready=1 at a rising edge, and SHALL deliver a beat iff out_valid=1 and out_ready=1.
REQ-019 SHALL present an accepted beat on out_* the cycle after acceptance when empty (latency 1).
REQ-020 SHALL preserve beat order, with no loss and no duplication.
REQ-021 SHALL drive out_ctrl=CTRL_BUBBLE whenever out_valid=0; out_data holds its last value.
REQ-022 SHALL force in_ready=0 while flush=1; no beat is accepted that cycle.
REQ-023 SHALL, on flush=1, set out_valid=0, empty all slots and set occupancy=0 at the next edge, regardless of out_ready.
REQ-024 SHALL, on flush=1, not alter stall_cnt for that cycle beyond REQ-025.
REQ-025 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF; stall_cnt_clr=1 SHALL take priority and load 0.
REQ-026 SHALL, when occupancy=1 and a delivery and an acceptance happen in the same cycle, replace the main slot with the new beat and keep occupancy=1.

Reset
REQ-027 SHALL, while rst_b=0 at an edge, set out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0, stall_cnt=0, and empty the skid slot.
REQ-028 SHALL drive in_ready=0 in any cycle where rst_b=0.
REQ-029 SHALL have reset take priority over flush, and flush take priority over the handshakes.

Configuration
REQ-030 SHALL use macro PIPE_SKID_EN.
REQ-031 SHALL, with PIPE_SKID_EN defined, include a second skid slot; in_ready SHALL be registered, equal to "skid slot empty"; a beat accepted while the main slot is valid and out_ready=0 SHALL go to the skid slot; the skid beat SHALL move to the main slot on the next delivery; full throughput SHALL hold at occupancy 0..2.
REQ-032 SHALL, without PIPE_SKID_EN, have a single slot with in_ready = !out_valid | out_ready (combinational), and occupancy SHALL never exceed 1.

Structure
REQ-033 SHALL place the occupancy typedef, the stall_cnt width constant and the CTRL_BUBBLE default in shared package pipe_pkg.
REQ-034 SHALL use sub-module pipe_slot (valid bit plus DATA_W+CTRL_W register with load, clear and sync reset) for both the main slot and the skid slot.

Verification
REQ-035 SHALL test: reset, then in_valid=1 with in_ctrl=24'h00ABCD and out_ready=1 -> out_valid=1 with out_ctrl=24'h00ABCD one cycle later, occupancy=1.
REQ-036 SHALL test (PIPE_SKID_EN): out_ready=0 while beats A and B are sent -> occupancy=2, in_ready=0, stall_cnt counting; release out_ready -> A then B delivered on consecutive cycles.
REQ-037 SHALL test: flush=1 at occupancy=2 with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0; the input beat is not accepted.
REQ-038 SHALL test: out_ready=0 held for 70000 cycles with a valid beat held -> stall_cnt=16'hFFFF; then stall_cnt_clr=1 -> stall_cnt=0 the next cycle.
REQ-039 SHALL test: rst_b=0 asserted mid-stream at occupancy=2 -> all outputs at reset values the next cycle, in_ready=0 during reset.
REQ-040 SHALL test: continuous in_valid=1 and out_ready=1 over 100 beats with incrementing data -> 100 beats delivered in order, no bubbles after the first.
